// File: rtl/ysyx_idu_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_idu_scoreboard_if
// Description : Bundle between the decode/commit side and the register
//               scoreboard. It carries the issue handshake, the execute
//               forward tap, commit, and branch resolve/squash. It also
//               carries the status outputs back to decode: pending table,
//               hazard, in-flight count and the sticky error flag.
//               Modports:
//                 master - decode / writeback side (drives requests)
//                 slave  - scoreboard side (drives ready and status)
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_idu_scoreboard_if #(
    parameter int NR_REG = 16,
    parameter int INFL_W = 3
);
    localparam int IDX_W = $clog2(NR_REG);

    logic              iss_valid;
    logic              iss_ready;
    logic [IDX_W-1:0]  iss_rs1;
    logic [IDX_W-1:0]  iss_rs2;
    logic              iss_use_rs1;
    logic              iss_use_rs2;
    logic              iss_wen;
    logic [IDX_W-1:0]  iss_rd;
    logic              iss_spec;
    logic              fwd_valid;
    logic [IDX_W-1:0]  fwd_rd;
    logic              cmt_valid;
    logic [IDX_W-1:0]  cmt_rd;
    logic              spec_resolve;
    logic              spec_squash;
    logic [NR_REG-1:0] rf_table;
    logic              hazard;
    logic [INFL_W-1:0] inflight;
    logic              sb_err;

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_use_rs1, iss_use_rs2,
               iss_wen, iss_rd, iss_spec, fwd_valid, fwd_rd,
               cmt_valid, cmt_rd, spec_resolve, spec_squash,
        input  iss_ready, rf_table, hazard, inflight, sb_err
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_use_rs1, iss_use_rs2,
               iss_wen, iss_rd, iss_spec, fwd_valid, fwd_rd,
               cmt_valid, cmt_rd, spec_resolve, spec_squash,
        output iss_ready, rf_table, hazard, inflight, sb_err
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_idu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_idu_scoreboard
// Description : Decode-stage register scoreboard and issue controller.
//               It counts the outstanding writes to each architectural
//               register (x0 is never pending) and the subset of those
//               writes that were issued speculatively. From these counts it
//               drives:
//                 - hazard    : a read operand of the presented
//                               instruction is pending and cannot be
//                               forwarded.
//                 - iss_ready : the instruction is accepted.
//               Commits release entries in order. A branch squash removes
//               every speculative write. A branch resolve turns the
//               speculative writes into architectural ones.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               sb    - ysyx_idu_scoreboard_if.slave bundle:
//                       iss_* issue handshake, fwd_* forward tap,
//                       cmt_* commit, spec_resolve / spec_squash,
//                       rf_table / hazard / inflight / sb_err status.
// Config      : YSYX_SB_BYPASS_EN - when defined, a commit to a source
//               register whose last pending write is retiring clears that
//               source's hazard in the same cycle. This requires the
//               register file to write through.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_idu_scoreboard #(
    parameter int NR_REG       = 16,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    ysyx_idu_scoreboard_if.slave   sb
);
    localparam int IDX_W  = $clog2(NR_REG);
    localparam int INFL_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]  r_pend      [NR_REG];
    logic [CNT_W-1:0]  r_spec_pend [NR_REG];
    logic [INFL_W-1:0] r_inflight;
    logic              r_sb_err;
    logic [NR_REG-1:0] r_rf_table;

    logic [CNT_W-1:0]  w_pend_nxt  [NR_REG];
    logic [CNT_W-1:0]  w_spec_nxt  [NR_REG];
    logic [NR_REG-1:0] w_pend_nz;
    logic [INFL_W-1:0] w_spec_sum;

    logic w_byp1, w_byp2;
    logic w_haz1, w_haz2, w_hazard;
    logic w_rd_full, w_ready;
    logic w_iss_inc;
    logic w_cmt_req, w_cmt_ok, w_cmt_bad;
    logic [CNT_W-1:0] w_cmt_avail;
    logic w_ovf;

    // ------------------------------------------------------------------
    // Same-cycle commit bypass for source operands
    // ------------------------------------------------------------------
`ifdef YSYX_SB_BYPASS_EN
    assign w_byp1 = sb.cmt_valid && (sb.cmt_rd == sb.iss_rs1)
                    && (r_pend[sb.iss_rs1] == CNT_W'(1));
    assign w_byp2 = sb.cmt_valid && (sb.cmt_rd == sb.iss_rs2)
                    && (r_pend[sb.iss_rs2] == CNT_W'(1));
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Hazard and issue ready (based on the current, not registered, pend)
    // ------------------------------------------------------------------
    assign w_haz1 = sb.iss_use_rs1 && (sb.iss_rs1 != '0)
                    && (r_pend[sb.iss_rs1] != '0)
                    && !(sb.fwd_valid && (sb.fwd_rd == sb.iss_rs1))
                    && !w_byp1;
    assign w_haz2 = sb.iss_use_rs2 && (sb.iss_rs2 != '0)
                    && (r_pend[sb.iss_rs2] != '0)
                    && !(sb.fwd_valid && (sb.fwd_rd == sb.iss_rs2))
                    && !w_byp2;
    assign w_hazard = sb.iss_valid && (w_haz1 || w_haz2);

    assign w_rd_full = sb.iss_wen && (sb.iss_rd != '0)
                       && (r_pend[sb.iss_rd] == C_CNT_MAX);
    assign w_ready   = !w_hazard && !sb.spec_squash
                       && (r_inflight < INFL_W'(MAX_INFLIGHT))
                       && !w_rd_full;

    // Only writes to a real register occupy a scoreboard slot.
    assign w_iss_inc = sb.iss_valid && w_ready && sb.iss_wen && (sb.iss_rd != '0);

    // ------------------------------------------------------------------
    // Commit. During a squash, the speculative writes to cmt_rd vanish in
    // the same edge. The commit may therefore only consume non-speculative
    // writes, or the counter would underflow.
    // ------------------------------------------------------------------
    assign w_cmt_req   = sb.cmt_valid && (sb.cmt_rd != '0);
    assign w_cmt_avail = sb.spec_squash ? (r_pend[sb.cmt_rd] - r_spec_pend[sb.cmt_rd])
                                        : r_pend[sb.cmt_rd];
    assign w_cmt_ok    = w_cmt_req && (w_cmt_avail != '0);
    assign w_cmt_bad   = w_cmt_req && (w_cmt_avail == '0);

    // Defensive check. The ready gating should make an increment of a
    // saturated counter impossible, but if it ever happens it is flagged.
    assign w_ovf = w_iss_inc && (r_pend[sb.iss_rd] == C_CNT_MAX)
                   && !(w_cmt_ok && (sb.cmt_rd == sb.iss_rd));

    // ------------------------------------------------------------------
    // Per-register next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_spec_sum = '0;
        w_pend_nz  = '0;
        for (int i = 0; i < NR_REG; i++) begin
            w_pend_nxt[i] = r_pend[i];
            w_spec_nxt[i] = r_spec_pend[i];
        end
        for (int i = 0; i < NR_REG; i++) begin
            w_spec_sum   = w_spec_sum + INFL_W'(r_spec_pend[i]);
            w_pend_nz[i] = (r_pend[i] != '0);

            w_pend_nxt[i] = r_pend[i]
                          - (sb.spec_squash ? r_spec_pend[i] : CNT_W'(0))
                          + CNT_W'(w_iss_inc && (sb.iss_rd == IDX_W'(i)))
                          - CNT_W'(w_cmt_ok  && (sb.cmt_rd == IDX_W'(i)));

            // A squash or a resolve retires the old speculative set. A
            // speculative issue in the same cycle belongs to a newer
            // branch, so it is counted on top of the cleared value.
            w_spec_nxt[i] = ((sb.spec_squash || sb.spec_resolve) ? CNT_W'(0) : r_spec_pend[i])
                          + CNT_W'(w_iss_inc && sb.iss_spec && (sb.iss_rd == IDX_W'(i)));
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_REG; i++) begin
                r_pend[i]      <= '0;
                r_spec_pend[i] <= '0;
            end
            r_inflight <= '0;
            r_sb_err   <= 1'b0;
            r_rf_table <= '0;
        end else begin
            for (int i = 0; i < NR_REG; i++) begin
                r_pend[i]      <= w_pend_nxt[i];
                r_spec_pend[i] <= w_spec_nxt[i];
            end
            r_inflight <= r_inflight
                        + INFL_W'(w_iss_inc)
                        - INFL_W'(w_cmt_ok)
                        - (sb.spec_squash ? w_spec_sum : INFL_W'(0));
            if (w_cmt_bad || w_ovf) begin
                r_sb_err <= 1'b1;
            end
            // The table lags pend by one cycle. Only hazard sees live state.
            r_rf_table <= w_pend_nz;
        end
    end

    assign sb.iss_ready = w_ready;
    assign sb.hazard    = w_hazard;
    assign sb.rf_table  = r_rf_table;
    assign sb.inflight  = r_inflight;
    assign sb.sb_err    = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_idu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_idu_scoreboard
// Description : Self-checking bench for ysyx_idu_scoreboard. The reference
//               model keeps a queue of the in-flight writes, each tagged
//               with its destination and speculation flag. The pending
//               counts, the in-flight total and the hazard/ready rules are
//               all derived from that queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_idu_scoreboard;
    logic clk;
    logic rst_n;

    ysyx_idu_scoreboard_if #(.NR_REG(16), .INFL_W(3)) sb_if ();

    ysyx_idu_scoreboard #(
        .NR_REG      (16),
        .CNT_W       (2),
        .MAX_INFLIGHT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb   (sb_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------
    typedef struct {
        logic [3:0] rd;
        bit         spec;
    } wr_t;

    wr_t         q[$];
    bit          m_err;
    logic [15:0] m_rf;
    int          n_vec;
    int          n_bad;

    function automatic int cnt(input logic [3:0] r);
        int c;
        c = 0;
        foreach (q[k]) if (q[k].rd == r) c++;
        return c;
    endfunction

    function automatic logic [15:0] pend_mask();
        logic [15:0] m;
        m = '0;
        for (int r = 1; r < 16; r++) m[r] = (cnt(r[3:0]) != 0);
        return m;
    endfunction

    function automatic bit src_haz(input bit use_rs, input logic [3:0] rs);
        bit h;
        h = use_rs && (rs != 0) && (cnt(rs) != 0)
            && !(sb_if.fwd_valid && sb_if.fwd_rd == rs);
`ifdef YSYX_SB_BYPASS_EN
        if (sb_if.cmt_valid && sb_if.cmt_rd == rs && cnt(rs) == 1) h = 1'b0;
`endif
        return h;
    endfunction

    function automatic bit m_hazard();
        return sb_if.iss_valid && (src_haz(sb_if.iss_use_rs1, sb_if.iss_rs1)
                                || src_haz(sb_if.iss_use_rs2, sb_if.iss_rs2));
    endfunction

    function automatic bit m_ready();
        return !m_hazard() && !sb_if.spec_squash && (q.size() < 4)
               && !(sb_if.iss_wen && sb_if.iss_rd != 0 && cnt(sb_if.iss_rd) == 3);
    endfunction

    task automatic model_reset();
        q.delete();
        m_err = 1'b0;
        m_rf  = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sb_if.iss_valid    = 1'b0;
        sb_if.iss_rs1      = '0;
        sb_if.iss_rs2      = '0;
        sb_if.iss_use_rs1  = 1'b0;
        sb_if.iss_use_rs2  = 1'b0;
        sb_if.iss_wen      = 1'b0;
        sb_if.iss_rd       = '0;
        sb_if.iss_spec     = 1'b0;
        sb_if.fwd_valid    = 1'b0;
        sb_if.fwd_rd       = '0;
        sb_if.cmt_valid    = 1'b0;
        sb_if.cmt_rd       = '0;
        sb_if.spec_resolve = 1'b0;
        sb_if.spec_squash  = 1'b0;
    endtask

    // Called just after a falling edge with the inputs already driven.
    // It compares every output with the model, crosses one rising edge
    // while the model takes the same step, and returns on the next
    // falling edge.
    task automatic tick();
        bit         acc, spec, cv, sq, rs;
        logic [3:0] rd, crd;
        int         k;
        #1;
        chk("hazard",    32'(sb_if.hazard),    32'(m_hazard()));
        chk("iss_ready", 32'(sb_if.iss_ready), 32'(m_ready()));
        chk("rf_table",  32'(sb_if.rf_table),  32'(m_rf));
        chk("inflight",  32'(sb_if.inflight),  32'(q.size()));
        chk("sb_err",    32'(sb_if.sb_err),    32'(m_err));
        acc  = sb_if.iss_valid && m_ready() && sb_if.iss_wen && (sb_if.iss_rd != 0);
        rd   = sb_if.iss_rd;
        spec = sb_if.iss_spec;
        cv   = sb_if.cmt_valid && (sb_if.cmt_rd != 0);
        crd  = sb_if.cmt_rd;
        sq   = sb_if.spec_squash;
        rs   = sb_if.spec_resolve;
        @(posedge clk);
        if (rst_n) begin
            m_rf = pend_mask();
            if (cv) begin
                k = -1;
                foreach (q[j]) if (k < 0 && q[j].rd == crd && !q[j].spec) k = j;
                if (k >= 0) q.delete(k);
                else        m_err = 1'b1;
            end
            if (sq) begin
                for (int j = q.size() - 1; j >= 0; j--) if (q[j].spec) q.delete(j);
            end else if (rs) begin
                foreach (q[j]) q[j].spec = 1'b0;
            end
            if (acc) q.push_back('{rd: rd, spec: spec});
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] rd, input bit spec);
        idle();
        sb_if.iss_valid = 1'b1;
        sb_if.iss_wen   = 1'b1;
        sb_if.iss_rd    = rd;
        sb_if.iss_spec  = spec;
        tick();
    endtask

    task automatic commit(input logic [3:0] rd);
        idle();
        sb_if.cmt_valid = 1'b1;
        sb_if.cmt_rd    = rd;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        model_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rf_table",  32'(sb_if.rf_table),  32'h0);
        chk("rst_inflight",  32'(sb_if.inflight),  32'h0);
        chk("rst_iss_ready", 32'(sb_if.iss_ready), 32'h1);
        chk("rst_sb_err",    32'(sb_if.sb_err),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // x0 is never pending and never stalls
        idle();
        sb_if.iss_valid = 1'b1;
        sb_if.iss_wen   = 1'b1;
        sb_if.iss_rd    = 4'd0;
        repeat (10) tick();
        idle(); tick();
        chk("x0_inflight", 32'(sb_if.inflight), 32'h0);
        chk("x0_rf_table", 32'(sb_if.rf_table), 32'h0);

        // squash drops the speculative writes only
        issue(4'd3, 1'b0);
        issue(4'd3, 1'b1);
        issue(4'd9, 1'b1);
        idle(); tick();
        chk("pre_sq_inflight", 32'(sb_if.inflight), 32'h3);
        chk("pre_sq_rf_table", 32'(sb_if.rf_table), 32'h0208);
        idle();
        sb_if.spec_squash = 1'b1;
        #1 chk("sq_ready", 32'(sb_if.iss_ready), 32'h0);
        tick();
        idle(); tick();
        chk("sq_inflight", 32'(sb_if.inflight), 32'h1);
        chk("sq_rf_table", 32'(sb_if.rf_table), 32'h0008);
        commit(4'd3);
        idle(); tick();

        // RAW hazard, released by commit
        issue(4'd5, 1'b0);
        idle();
        sb_if.iss_valid   = 1'b1;
        sb_if.iss_use_rs1 = 1'b1;
        sb_if.iss_rs1     = 4'd5;
        #1;
        chk("raw_hazard", 32'(sb_if.hazard),    32'h1);
        chk("raw_ready",  32'(sb_if.iss_ready), 32'h0);
        sb_if.cmt_valid = 1'b1;
        sb_if.cmt_rd    = 4'd5;
`ifdef YSYX_SB_BYPASS_EN
        #1 chk("raw_cmt_hazard", 32'(sb_if.hazard), 32'h0);
`else
        #1 chk("raw_cmt_hazard", 32'(sb_if.hazard), 32'h1);
`endif
        tick();
        sb_if.cmt_valid = 1'b0;
        #1;
        chk("raw_after_hazard", 32'(sb_if.hazard),    32'h0);
        chk("raw_after_ready",  32'(sb_if.iss_ready), 32'h1);
        tick();
        idle(); tick();

        // forwarding hides a pending source
        issue(4'd7, 1'b0);
        idle();
        sb_if.iss_valid   = 1'b1;
        sb_if.iss_use_rs2 = 1'b1;
        sb_if.iss_rs2     = 4'd7;
        sb_if.fwd_valid   = 1'b1;
        sb_if.fwd_rd      = 4'd7;
        #1;
        chk("fwd_hazard", 32'(sb_if.hazard),    32'h0);
        chk("fwd_ready",  32'(sb_if.iss_ready), 32'h1);
        tick();
        commit(4'd7);

        // in-flight limit, per-register limit, sticky error
        for (int r = 1; r <= 4; r++) issue(4'(r), 1'b0);
        idle();
        sb_if.iss_valid = 1'b1;
        sb_if.iss_wen   = 1'b1;
        sb_if.iss_rd    = 4'd6;
        #1;
        chk("lim_ready",    32'(sb_if.iss_ready), 32'h0);
        chk("lim_inflight", 32'(sb_if.inflight),  32'h4);
        tick();
        for (int r = 1; r <= 4; r++) commit(4'(r));
        repeat (3) issue(4'd2, 1'b0);
        idle();
        sb_if.iss_valid = 1'b1;
        sb_if.iss_wen   = 1'b1;
        sb_if.iss_rd    = 4'd2;
        #1 chk("rd_full_ready", 32'(sb_if.iss_ready), 32'h0);
        tick();
        repeat (3) commit(4'd2);
        idle(); tick();
        chk("err_before", 32'(sb_if.sb_err), 32'h0);
        commit(4'd4);
        idle(); tick();
        chk("err_set", 32'(sb_if.sb_err), 32'h1);
        repeat (5) begin idle(); tick(); end
        chk("err_sticky", 32'(sb_if.sb_err), 32'h1);

        // asynchronous reset in mid-run
        issue(4'd5, 1'b0);
        issue(4'd5, 1'b0);
        idle(); tick();
        chk("pre_rst_rf_table", 32'(sb_if.rf_table), 32'h0020);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rf_table",  32'(sb_if.rf_table),  32'h0);
        chk("arst_inflight",  32'(sb_if.inflight),  32'h0);
        chk("arst_iss_ready", 32'(sb_if.iss_ready), 32'h1);
        chk("arst_sb_err",    32'(sb_if.sb_err),    32'h0);
        model_reset();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();

        // randomized traffic
        repeat (3000) begin
            idle();
            sb_if.iss_valid    = ($urandom_range(0, 9) < 7);
            sb_if.iss_rs1      = 4'($urandom_range(0, 7));
            sb_if.iss_rs2      = 4'($urandom_range(0, 7));
            sb_if.iss_use_rs1  = 1'($urandom_range(0, 1));
            sb_if.iss_use_rs2  = 1'($urandom_range(0, 1));
            sb_if.iss_wen      = ($urandom_range(0, 3) != 0);
            sb_if.iss_rd       = 4'($urandom_range(0, 7));
            sb_if.fwd_valid    = ($urandom_range(0, 3) == 0);
            sb_if.fwd_rd       = 4'($urandom_range(0, 7));
            sb_if.spec_resolve = ($urandom_range(0, 19) == 0);
            sb_if.spec_squash  = ($urandom_range(0, 19) == 0);
            sb_if.iss_spec     = sb_if.spec_resolve ? 1'b0 : 1'($urandom_range(0, 1));
            if (q.size() > 0 && !q[0].spec && $urandom_range(0, 2) == 0) begin
                sb_if.cmt_valid = 1'b1;
                sb_if.cmt_rd    = q[0].rd;
            end else if ($urandom_range(0, 49) == 0) begin
                for (int r = 1; r <= 7; r++) begin
                    if (!sb_if.cmt_valid && cnt(4'(r)) == 0) begin
                        sb_if.cmt_valid = 1'b1;
                        sb_if.cmt_rd    = 4'(r);
                    end
                end
            end
            tick();
        end

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
